// File: rtl/hazard_scoreboard.sv
// Hazard / forwarding scoreboard for the in-order pipeline: tracks in-flight
// register writes past decode and picks a forwarding source or stall per operand.
module hazard_scoreboard #(
    parameter int REG_AW      = 3,
    parameter int NUM_SRC     = 2,
    parameter int DEPTH       = 2,
    parameter int LOAD_STAGE  = 1,
    parameter int ZERO_REG_EN = 0,
    parameter int CNT_W       = 16,
    parameter int SEL_W       = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REG_AW-1:0]  id_src_addr,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [REG_AW-1:0]          id_dst_addr,
    input  logic                       id_dst_wr,
    input  logic                       id_is_load,
    input  logic                       flush,
    input  logic                       mem_done,
    output logic                       stall,
    output logic                       freeze,
    output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
    output logic [CNT_W-1:0]           stall_cnt
);

    logic [DEPTH-1:0]   vld;
    logic [REG_AW-1:0]  dst [DEPTH];
    logic [SEL_W-1:0]   rdy [DEPTH];

    logic [NUM_SRC-1:0]        haz;
    logic [NUM_SRC*SEL_W-1:0]  sel;
    logic [REG_AW-1:0]         addr;
    logic                      hz;

    // Scan oldest to youngest so the youngest matching entry overrides.
    always_comb begin
        haz  = '0;
        sel  = '0;
        addr = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            addr = id_src_addr[s*REG_AW +: REG_AW];
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (id_valid && id_src_used[s] && vld[k] && (dst[k] == addr) &&
                    !((ZERO_REG_EN != 0) && (addr == '0))) begin
                    if (SEL_W'(k) >= rdy[k]) begin
                        sel[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        haz[s]                = 1'b0;
                    end else begin
                        sel[s*SEL_W +: SEL_W] = '0;
                        haz[s]                = 1'b1;
                    end
                end
            end
        end
    end

    assign hz      = (|haz) & ~flush;
    assign stall   = ~rst_n | hz | ~mem_done;
    assign freeze  = ~mem_done;
    assign fwd_sel = rst_n ? sel : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld       <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dst[k] <= '0;
                rdy[k] <= '0;
            end
        end else if (mem_done) begin
            // A stalled or flushed decode slot enters EX as a bubble.
            vld[0] <= id_valid & id_dst_wr & ~flush & ~hz;
            dst[0] <= id_dst_addr;
            rdy[0] <= id_is_load ? SEL_W'(LOAD_STAGE) : '0;
            for (int k = 1; k < DEPTH; k++) begin
                vld[k] <= vld[k-1];
                dst[k] <= dst[k-1];
                rdy[k] <= rdy[k-1];
            end
            if (hz && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a default instance plus a ZERO_REG_EN=1, CNT_W=4
// instance on shared stimulus, table vectors and hand sequences.
module tb_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [5:0]  id_src_addr;
    logic [1:0]  id_src_used;
    logic [2:0]  id_dst_addr;
    logic        id_dst_wr;
    logic        id_is_load;
    logic        flush;
    logic        mem_done;
    logic        stall, freeze, stall2, freeze2;
    logic [3:0]  fwd_sel, fwd_sel2;
    logic [15:0] stall_cnt;
    logic [3:0]  stall_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_wr(id_dst_wr),
        .id_is_load(id_is_load), .flush(flush), .mem_done(mem_done),
        .stall(stall), .freeze(freeze), .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.ZERO_REG_EN(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_dst_wr(id_dst_wr),
        .id_is_load(id_is_load), .flush(flush), .mem_done(mem_done),
        .stall(stall2), .freeze(freeze2), .fwd_sel(fwd_sel2), .stall_cnt(stall_cnt2)
    );

    typedef struct {
        logic       v;
        logic [2:0] s0, s1;
        logic [1:0] used;
        logic [2:0] d;
        logic       wr, ld, fl, md;
        logic       e_stall, e_freeze;
        logic [3:0] e_sel;
        logic [15:0] e_cnt;
    } vec_t;

    typedef struct packed {
        logic        stall, freeze;
        logic [3:0]  sel;
        logic [15:0] cnt;
    } exp_t;

    vec_t tbl[25];
    exp_t exp_q[$];

    function automatic vec_t mk(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                                input logic [1:0] used, input logic [2:0] d, input logic wr,
                                input logic ld, input logic fl, input logic md,
                                input logic es, input logic ef, input logic [3:0] esel,
                                input logic [15:0] ecnt);
        vec_t r;
        r.v = v; r.s0 = s0; r.s1 = s1; r.used = used; r.d = d;
        r.wr = wr; r.ld = ld; r.fl = fl; r.md = md;
        r.e_stall = es; r.e_freeze = ef; r.e_sel = esel; r.e_cnt = ecnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] s0, input logic [2:0] s1,
                         input logic [1:0] used, input logic [2:0] d, input logic wr,
                         input logic ld, input logic fl, input logic md);
        id_valid    = v;
        id_src_addr = {s1, s0};
        id_src_used = used;
        id_dst_addr = d;
        id_dst_wr   = wr;
        id_is_load  = ld;
        flush       = fl;
        mem_done    = md;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        // v s0 s1 used d wr ld fl md | stall freeze sel cnt
        tbl[0]  = mk(1,0,0,2'b00,3,1,0,0,1, 0,0,4'b0000,0);  // ALU r3
        tbl[1]  = mk(1,3,1,2'b01,0,0,0,0,1, 0,0,4'b0001,0);
        tbl[2]  = mk(1,3,1,2'b01,0,0,0,0,1, 0,0,4'b0010,0);
        tbl[3]  = mk(1,3,1,2'b01,0,0,0,0,1, 0,0,4'b0000,0);
        tbl[4]  = mk(1,0,0,2'b00,5,1,1,0,1, 0,0,4'b0000,0);  // load r5
        tbl[5]  = mk(1,0,5,2'b10,0,0,0,0,1, 1,0,4'b0000,0);
        tbl[6]  = mk(1,0,5,2'b10,0,0,0,0,1, 0,0,4'b1000,1);
        tbl[7]  = mk(1,0,0,2'b00,2,1,0,0,1, 0,0,4'b0000,1);  // r2 twice
        tbl[8]  = mk(1,0,0,2'b00,2,1,0,0,1, 0,0,4'b0000,1);
        tbl[9]  = mk(1,2,2,2'b11,0,0,0,0,1, 0,0,4'b0101,1);
        tbl[10] = mk(1,2,0,2'b01,0,0,0,0,1, 0,0,4'b0010,1);
        tbl[11] = mk(1,0,0,2'b00,4,1,1,0,1, 0,0,4'b0000,1);  // load r4, freeze
        tbl[12] = mk(1,4,0,2'b01,0,0,0,0,0, 1,1,4'b0000,1);
        tbl[13] = mk(1,4,0,2'b01,0,0,0,0,0, 1,1,4'b0000,1);
        tbl[14] = mk(1,4,0,2'b01,0,0,0,0,0, 1,1,4'b0000,1);
        tbl[15] = mk(1,4,0,2'b01,0,0,0,0,1, 1,0,4'b0000,1);
        tbl[16] = mk(1,4,0,2'b01,0,0,0,0,1, 0,0,4'b0010,2);
        tbl[17] = mk(1,0,0,2'b00,6,1,1,0,1, 0,0,4'b0000,2);  // load r6, flush
        tbl[18] = mk(1,6,0,2'b01,7,1,0,1,1, 0,0,4'b0000,2);
        tbl[19] = mk(1,7,6,2'b11,0,0,0,0,1, 0,0,4'b1000,2);
        tbl[20] = mk(0,0,0,2'b00,0,0,0,0,0, 1,1,4'b0000,2);
        tbl[21] = mk(0,0,0,2'b00,0,0,0,0,1, 0,0,4'b0000,2);
        tbl[22] = mk(1,0,0,2'b00,1,1,0,0,1, 0,0,4'b0000,2);  // invalid slot
        tbl[23] = mk(0,1,0,2'b01,0,0,0,0,1, 0,0,4'b0000,2);
        tbl[24] = mk(1,1,0,2'b01,0,0,0,0,1, 0,0,4'b0010,2);

        rst_n = 1'b0;
        drive(0,0,0,2'b00,0,0,0,0,1);
        #2;
        check("reset stall", {31'b0, stall}, 1);
        check("reset freeze", {31'b0, freeze}, 0);
        check("reset fwd_sel", {28'b0, fwd_sel}, 0);
        check("reset stall_cnt", {16'b0, stall_cnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post-reset stall", {31'b0, stall}, 0);

        for (int i = 0; i < 25; i++) begin
            drive(tbl[i].v, tbl[i].s0, tbl[i].s1, tbl[i].used, tbl[i].d,
                  tbl[i].wr, tbl[i].ld, tbl[i].fl, tbl[i].md);
            exp_q.push_back('{tbl[i].e_stall, tbl[i].e_freeze, tbl[i].e_sel, tbl[i].e_cnt});
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("row%0d stall", i), {31'b0, stall}, {31'b0, e.stall});
            check($sformatf("row%0d freeze", i), {31'b0, freeze}, {31'b0, e.freeze});
            check($sformatf("row%0d fwd_sel", i), {28'b0, fwd_sel}, {28'b0, e.sel});
            check($sformatf("row%0d stall_cnt", i), {16'b0, stall_cnt}, {16'b0, e.cnt});
            check($sformatf("row%0d fwd_sel2", i), {28'b0, fwd_sel2}, {28'b0, e.sel});
            check($sformatf("row%0d stall2", i), {31'b0, stall2}, {31'b0, e.stall});
            check($sformatf("row%0d stall_cnt2", i), {28'b0, stall_cnt2}, {28'b0, e.cnt[3:0]});
            @(posedge clk);
            #1;
        end

        // r0 writers: only the ZERO_REG_EN instance ignores them
        drive(1,0,0,2'b00,0,1,0,0,1);
        tick();
        drive(1,0,0,2'b01,0,0,0,0,1);
        #1;
        check("zero alu fwd main", {28'b0, fwd_sel}, 4'b0001);
        check("zero alu fwd zen", {28'b0, fwd_sel2}, 0);
        check("zero alu stall zen", {31'b0, stall2}, 0);
        tick();
        drive(1,0,0,2'b00,0,1,1,0,1);
        tick();
        drive(1,0,0,2'b10,0,0,0,0,1);
        #1;
        check("zero load stall main", {31'b0, stall}, 1);
        check("zero load stall zen", {31'b0, stall2}, 0);
        tick();
        drive(0,0,0,2'b00,0,0,0,0,1);
        #1;
        check("zero cnt main", {16'b0, stall_cnt}, 3);
        check("zero cnt zen", {28'b0, stall_cnt2}, 2);
        tick();

        // 20 load-use hazard cycles: 4-bit counter must stick at 15
        for (int i = 0; i < 20; i++) begin
            drive(1,0,0,2'b00,5,1,1,0,1);
            tick();
            drive(1,5,0,2'b01,0,0,0,0,1);
            #1;
            if (i == 0) check("sat hazard stall", {31'b0, stall2}, 1);
            tick();
            if (i == 9) check("sat cnt2 mid", {28'b0, stall_cnt2}, 12);
        end
        drive(0,0,0,2'b00,0,0,0,0,1);
        #1;
        check("sat cnt2 final", {28'b0, stall_cnt2}, 15);
        check("sat cnt main", {16'b0, stall_cnt}, 23);
        tick();

        // asynchronous reset in the middle of a load-use stall
        drive(1,0,0,2'b00,5,1,1,0,1);
        tick();
        drive(1,5,0,2'b01,0,0,0,0,1);
        #1;
        check("pre-reset hazard", {31'b0, stall}, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async cnt main", {16'b0, stall_cnt}, 0);
        check("async cnt zen", {28'b0, stall_cnt2}, 0);
        check("async stall", {31'b0, stall}, 1);
        check("async fwd_sel", {28'b0, fwd_sel}, 0);
        check("async freeze", {31'b0, freeze}, 0);
        mem_done = 1'b0;
        #1;
        check("reset freeze follows", {31'b0, freeze}, 1);
        mem_done = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release no hazard", {31'b0, stall}, 0);
        check("release fwd_sel", {28'b0, fwd_sel}, 0);
        tick();
        check("release cnt", {16'b0, stall_cnt}, 0);
        check("release stall after edge", {31'b0, stall}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
